// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Purpose  : Shared types and width helpers for the handshaked data memory.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Either bit set makes the request an error response with no side effects.
    typedef struct packed {
        logic out_of_range;
        logic misaligned;
    } err_t;

    function automatic int ofs_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_bank.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_bank
// Purpose  : DEPTH x DATA_W word array, byte-strobed write, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_bank #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents are deliberately not reset; the read register only moves on a read.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Purpose  : Handshaked load/store data memory with error response.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_OFS    = ofs_w(DATA_W);
    localparam int c_IDX_W  = idx_w(DEPTH);
    localparam int c_HI     = c_OFS + c_IDX_W;

    state_t              r_state;
    logic                r_rsp_err;
    logic                r_rsp_rd;
    logic                w_accept;
    logic                w_misaligned;
    logic                w_out_of_range;
    err_t                w_err;
    logic                w_bad;
    logic [c_IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0]   w_bank_rdata;

    generate
        if (c_OFS > 0) begin : g_align
            assign w_misaligned = |req_addr[c_OFS-1:0];
        end else begin : g_no_align
            assign w_misaligned = 1'b0;
        end

        if (ADDR_W > c_HI) begin : g_range
            assign w_out_of_range = |req_addr[ADDR_W-1:c_HI];
        end else begin : g_no_range
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    assign w_err    = '{out_of_range: w_out_of_range, misaligned: w_misaligned};
    assign w_bad    = |w_err;
    assign w_idx    = req_addr[c_HI-1:c_OFS];

    assign req_ready = !rst && (r_state == ST_EMPTY || rsp_ready);
    assign w_accept  = req_valid && req_ready;

    data_mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (c_IDX_W),
        .STRB_W (c_STRB_W)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_accept && req_we && !w_bad),
        .i_re    (w_accept && !req_we && !w_bad),
        .i_idx   (w_idx),
        .i_wstrb (req_wstrb),
        .i_wdata (req_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Acceptance only happens when the slot is empty or being drained this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_EMPTY;
            r_rsp_err <= 1'b0;
            r_rsp_rd  <= 1'b0;
        end else if (w_accept) begin
            r_state   <= ST_FULL;
            r_rsp_err <= w_bad;
            r_rsp_rd  <= !req_we && !w_bad;
        end else if (r_state == ST_FULL && rsp_ready) begin
            r_state   <= ST_EMPTY;
        end
    end

    // The bank read register is only reloaded on an accepted read, so it holds while stalled.
    assign rsp_valid = (r_state == ST_FULL);
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rd ? w_bank_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Purpose  : Scoreboard bench for data_mem_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wstrb (req_wstrb),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per completed response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
                end else begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wstrb = strb;
        req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 for addr %h", addr);
        end else begin
            e.rdata = exp_rd;
            e.err   = exp_err;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wstrb = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_err", {31'b0, rsp_err}, 32'd0);
        @(posedge clk);
        #1;

        // Full word write then back-to-back read of the same word.
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        drain();

        // Byte strobes: lanes 0 and 2 updated.
        issue(1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0);
        issue(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
        issue(1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0);

        // Errors: misaligned read, out-of-range write leaves word 0 alone.
        issue(1'b0, 32'h22, 4'h0, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 32'h00, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b1, 32'h200, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
        issue(1'b1, 32'h01, 4'hF, 32'h12345678, 32'h0, 1'b1);
        issue(1'b0, 32'h00, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        drain();

        // Back-pressure: held response stays stable, stalled write is not taken.
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wstrb = 4'hF;
        req_wdata = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", {31'b0, rsp_valid}, 32'd1);
            check("stall_ready", {31'b0, req_ready}, 32'd0);
            check("stall_rdata", rsp_rdata, 32'hDEADBEEF);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("consumed_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        drain();

        // Throughput: eight reads answered in eight consecutive cycles.
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 32'h40 + 32'(4 * i), 4'hF, 32'h10000000 + 32'(i), 32'h0, 1'b0);
        end
        drain();
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 32'h40 + 32'(4 * i), 4'h0, 32'h0, 32'h10000000 + 32'(i), 1'b0);
        end
        drain();
        check("tput_count", pop_cyc.size(), 32'd8);
        if (pop_cyc.size() == 8) begin
            for (int i = 1; i < 8; i++) begin
                check("tput_gap", pop_cyc[i] - pop_cyc[i-1], 32'd1);
            end
        end

        // Reset while a response is held and a write is presented.
        issue(1'b1, 32'h30, 4'hF, 32'h30303030, 32'h0, 1'b0);
        drain();
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wstrb = 4'hF;
        req_wdata = 32'hBAD0BAD0;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_drop_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_drop_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h30, 4'h0, 32'h0, 32'h30303030, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked data memory for the CPU load/store path, generalising the fixed 512-byte word RAM. Depth and data width are parametrised. Writes use per-byte strobes. Reads are synchronous, with a one-cycle registered response. Every accepted request returns exactly one response, with an error flag for misaligned or out-of-range addresses. It sits between the memory stage and the data address space and can back-pressure the pipeline.

## Interface
Parameters:
- ADDR_W, 32, request address width in bits (byte address)
- DATA_W, 32, word width in bits; multiple of 8; STRB_W = DATA_W/8
- DEPTH, 128, number of words; power of two, at least 2

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wstrb  in  STRB_W  byte-lane enables for writes; ignored on reads
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  request was misaligned or out of range

## Operation
- OFS = log2(STRB_W) and IDX_W = log2(DEPTH); word index = req_addr[OFS+IDX_W-1:OFS].
- An error is flagged when req_addr[OFS-1:0] != 0 (misaligned) or req_addr[ADDR_W-1:OFS+IDX_W] != 0 (out of range).
- Errored requests never modify memory. They return rsp_rdata = 0 and rsp_err = 1.
- Accepted write, no error: for each lane i with req_wstrb[i] = 1, byte i of word[index] takes req_wdata byte i. Other lanes are unchanged. If req_wstrb = 0, nothing changes, but a response is still returned with rsp_err = 0.
- Accepted read, no error: rsp_rdata = word[index] as it stood after all previously accepted writes.
- Output state machine has two states:
  - EMPTY: rsp_valid = 0. An accepted request moves to FULL.
  - FULL: rsp_valid = 1.
    - rsp_ready = 1 with a new request accepted: stay in FULL; the response registers load the new result.
    - rsp_ready = 1 with no request: go to EMPTY.
    - rsp_ready = 0: stay in FULL; the response is held.
- req_ready = !rst && (state == EMPTY || rsp_ready). This allows full throughput of one request per cycle when rsp_ready is held high.
- While a response is stalled, rsp_rdata and rsp_err stay bit-stable. A later write to the same word must not alter the held rsp_rdata, because no request is accepted while stalled.
- Memory contents are not reset and are undefined until written. A bench must write before it reads.

## Timing
- Request accepted at edge N: the memory write takes effect at edge N; rsp_valid, rsp_rdata and rsp_err are valid after edge N (visible in cycle N+1).
- Read-after-write, back to back: write accepted at N, read of the same word accepted at N+1. The read response, visible in cycle N+2, carries the new data; no forwarding path is needed.
- Reset values after any edge with rst = 1: state EMPTY, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0. req_ready is 0 while rst = 1.
- Reset mid-operation:
  - A held response is dropped.
  - A request presented in a cycle with rst = 1 is not accepted, and its write is not performed.
- Output registers are the only registered outputs; req_ready is combinational from state, rst and rsp_ready.
- No combinational path from req_* to rsp_*.

## Structure
- Shared package data_mem_pkg:
  - localparam helpers for OFS and IDX_W (clog2-based)
  - state encoding typedef: EMPTY, FULL
  - err_t bit meanings
- One sub-module, data_mem_bank:
  - DEPTH x DATA_W array with byte-strobe synchronous write and synchronous registered read
  - read enable gated by accept && !req_we && !err
- The top, data_mem_ctrl, holds address decode, error detection, the handshake state machine, and the response registers (capture bank output or zero, plus err).

## Test plan
- Reset, then write 0xDEADBEEF to address 0x10 with wstrb = 0xF, then read 0x10 → responses are (0, err = 0) then (0xDEADBEEF, err = 0); read response in cycle N+2 after a write at N.
- Byte strobes: write 0x11223344 to 0x20, then write 0xAABBCCDD with wstrb = 0b0101, then read 0x20 → 0x11BB33DD.
- Errors:
  - read 0x22 → rsp_err = 1, rdata = 0
  - write to 4*DEPTH (0x200 at defaults), then read word 0 → err = 1; word 0 unchanged
- Back-pressure: hold rsp_ready = 0 for 3 cycles after a read of 0x10 → req_ready = 0 and rsp_rdata stable at 0xDEADBEEF; raising rsp_ready consumes it in 1 cycle.
- Throughput: 8 consecutive reads with rsp_ready = 1 → 8 responses in 8 consecutive cycles, in order.
- Reset mid-operation: assert rst while a response is held and a write to 0x30 is presented → rsp_valid = 0 next cycle; a subsequent read of 0x30 returns its pre-reset value.
